// File: rtl/riscv_lsu_pkg.sv
// Shared constants for the load/store unit: data/address widths, funct3
// encodings, FSM state encoding and the request legality check.
package riscv_lsu_pkg;

  localparam int XLEN          = 32;
  localparam int DMEM_ADDR_BIT = 10;
  localparam int WADDR_BIT     = DMEM_ADDR_BIT - 2;
  localparam int NLANE         = XLEN / 8;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } lsu_state_e;

  // A request may touch memory only with a known width, no unsigned store,
  // and natural alignment for halfwords and words.
  function automatic logic lsu_req_ok(input logic we, input logic [2:0] f3,
                                      input logic [1:0] alo);
    logic ok;
    ok = 1'b0;
    case (f3)
      LSU_B:  ok = 1'b1;
      LSU_H:  ok = ~alo[0];
      LSU_W:  ok = (alo == 2'b00);
      LSU_BU: ok = ~we;
      LSU_HU: ok = ~we & ~alo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/riscv_lsu_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface riscv_lsu_if;
  import riscv_lsu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/riscv_dmem.sv
// Word-addressed data memory with byte-lane write enables and combinational read.
module riscv_dmem
  import riscv_lsu_pkg::*;
(
  input  logic                 i_clk,
  input  logic [WADDR_BIT-1:0] i_addr,
  input  logic [NLANE-1:0]     i_byte_sel,
  input  logic [XLEN-1:0]      i_data,
  input  logic                 i_wr_en,
  output logic [XLEN-1:0]      o_data
);

  logic [XLEN-1:0] mem_q [2**WADDR_BIT];

  // Byte-masked write on the rising edge.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      for (int i = 0; i < NLANE; i++) begin
        if (i_byte_sel[i]) mem_q[i_addr][i*8 +: 8] <= i_data[i*8 +: 8];
      end
    end
  end

  assign o_data = mem_q[i_addr];

endmodule

// File: rtl/riscv_lsu_align.sv
// Load alignment: picks the addressed lane from the read word and extends it.
module riscv_lsu_align
  import riscv_lsu_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_word,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] byte_sh;
  logic [XLEN-1:0] half_sh;

  // Shift the wanted lane down to bit 0, then extend according to funct3.
  always_comb begin
    byte_sh = i_word >> {i_addr_lo, 3'b000};
    half_sh = i_word >> {i_addr_lo[1], 4'b0000};
    case (i_funct3)
      LSU_B:   o_rdata = {{24{byte_sh[7]}}, byte_sh[7:0]};
      LSU_BU:  o_rdata = {24'h0, byte_sh[7:0]};
      LSU_H:   o_rdata = {{16{half_sh[15]}}, half_sh[15:0]};
      LSU_HU:  o_rdata = {16'h0, half_sh[15:0]};
      default: o_rdata = i_word;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: accepts one request at a time, drives the data memory for
// one ACCESS cycle, and returns aligned load data or a store/error response.
//
// state    | meaning
// S_IDLE   | ready for a request
// S_ACCESS | memory port driven from registered request fields
// S_RESP   | one-cycle response (data, store ack or error)
module riscv_lsu
  import riscv_lsu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rstn,
  riscv_lsu_if.slave           req_if,
  output logic [WADDR_BIT-1:0] o_dmem_addr,
  output logic [NLANE-1:0]     o_dmem_byte_sel,
  output logic [XLEN-1:0]      o_dmem_data,
  output logic                 o_dmem_wr_en,
  input  logic [XLEN-1:0]      i_dmem_data
);

  lsu_state_e           state_q, state_d;
  logic                 we_q, we_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           alo_q, alo_d;
  logic [NLANE-1:0]     sel_q, sel_d;
  logic [WADDR_BIT-1:0] daddr_q, daddr_d;
  logic [XLEN-1:0]      ddata_q, ddata_d;
  logic                 err_q, err_d;
  logic [XLEN-1:0]      rdata_q, rdata_d;
  logic [XLEN-1:0]      load_word;
  logic [NLANE-1:0]     req_sel;
  logic [XLEN-1:0]      req_sdata;
  logic                 unused_addr_hi;

  // Upper address bits are dropped so accesses wrap modulo memory size.
  assign unused_addr_hi = ^req_if.req_addr[XLEN-1:DMEM_ADDR_BIT];

  riscv_lsu_align u_align (
    .i_funct3  (f3_q),
    .i_addr_lo (alo_q),
    .i_word    (i_dmem_data),
    .o_rdata   (load_word)
  );

  // Lane enables and lane-replicated store data for the incoming request.
  always_comb begin
    case (req_if.req_funct3[1:0])
      2'b00:   req_sel = 4'b0001 << req_if.req_addr[1:0];
      2'b01:   req_sel = 4'b0011 << req_if.req_addr[1:0];
      default: req_sel = 4'b1111;
    endcase
    case (req_if.req_funct3[1:0])
      2'b00:   req_sdata = {4{req_if.req_wdata[7:0]}};
      2'b01:   req_sdata = {2{req_if.req_wdata[15:0]}};
      default: req_sdata = req_if.req_wdata;
    endcase
  end

  // Next-state and register update; ready is implied by being in S_IDLE.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    sel_d   = sel_q;
    daddr_d = daddr_q;
    ddata_d = ddata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_if.req_valid) begin
          rdata_d = '0;
          if (lsu_req_ok(req_if.req_we, req_if.req_funct3, req_if.req_addr[1:0])) begin
            state_d = S_ACCESS;
            err_d   = 1'b0;
            we_d    = req_if.req_we;
            f3_d    = req_if.req_funct3;
            alo_d   = req_if.req_addr[1:0];
            sel_d   = req_sel;
            daddr_d = req_if.req_addr[DMEM_ADDR_BIT-1:2];
            ddata_d = req_sdata;
          end else begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        state_d = S_RESP;
        rdata_d = we_q ? '0 : load_word;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight request.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      alo_q   <= 2'b00;
      sel_q   <= '0;
      daddr_q <= '0;
      ddata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      sel_q   <= sel_d;
      daddr_q <= daddr_d;
      ddata_q <= ddata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_if.req_ready = (state_q == S_IDLE);
  assign req_if.rsp_valid = (state_q == S_RESP);
  assign req_if.rsp_rdata = rdata_q;
  assign req_if.rsp_err   = err_q;
  assign o_dmem_addr      = daddr_q;
  assign o_dmem_data      = ddata_q;
  assign o_dmem_byte_sel  = (state_q == S_ACCESS) ? sel_q : '0;
  assign o_dmem_wr_en     = (state_q == S_ACCESS) & we_q;

endmodule
